rv32_gpio_ctrl: RTL and testbench
=================================

# rv32_gpio_ctrl

Parametrised memory-mapped GPIO controller for the RV32I pipeline's I/O region (base 0x8000_0000). Generalises the pushbutton/LED port to NUM_PB debounced inputs and NUM_LED outputs, with atomic LED set/clear, sticky rising-edge status (write-1-to-clear) and a maskable level interrupt. Sits on the same word-addressed I/O bus as the data-memory path; read data is registered (1-cycle latency).

## Interface

Parameters:
- NUM_PB, default 4, number of pushbutton inputs (1..32)
- NUM_LED, default 10, number of LED outputs (1..32)
- DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept an input change (≥2); counter width = $clog2(DEBOUNCE_CYCLES)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- io_addr  in  30 [31:2]  word address; only [4:2] decoded, upper bits already qualified upstream
- io_wdata  in  32  write data
- io_we  in  1  write strobe, one transfer per cycle high
- io_be  in  4  byte enables for writes
- io_rdata  out  32  registered read data
- pushbuttons  in  NUM_PB  asynchronous raw button levels
- leds  out  NUM_LED  LED drive register
- irq  out  1  registered interrupt request, level, active-high

## Operation

Register map (offset = io_addr[4:2]×4):
- 0x00 PB_LEVEL RO: debounced levels, bits [NUM_PB-1:0]
- 0x04 LED RW: byte-enabled write of leds
- 0x08 LED_SET WO: leds |= wdata (per enabled byte); reads 0
- 0x0C LED_CLR WO: leds &= ~wdata (per enabled byte); reads 0
- 0x10 PB_EDGE RW1C: sticky rising-edge flags; writing 1 clears (per enabled byte)
- 0x14 IRQ_EN RW: per-button interrupt enable
- 0x18, 0x1C: unmapped, read 0, writes ignored
- Bits above NUM_PB/NUM_LED: writes dropped, read 0. Writes to RO offset ignored.

Input path per channel:
- 2-flop synchroniser → sync.
- Debounce: counter cnt, accepted level stable. If sync == stable, cnt ← 0. Else if cnt == DEBOUNCE_CYCLES-1, stable ← sync, cnt ← 0. Else cnt ← cnt+1.
- When stable goes 0→1, PB_EDGE[i] ← 1 on the same edge.
- Simultaneous edge set and W1C clear of the same bit: set wins (flag remains 1).
- Falling edges do not set flags.

Interrupt: irq ← |(PB_EDGE & IRQ_EN) registered; no other sources.

Reads: every cycle io_rdata ← value at io_addr[4:2], independent of io_we; no read side effects.

## Timing

- Reset (reset=0, async): leds=0, io_rdata=0, irq=0, PB_EDGE=0, IRQ_EN=0, stable=0, cnt=0, sync flops=0. Buttons already held high at release produce a rising edge after debounce (set PB_EDGE).
- Read latency 1 cycle: address at edge k → io_rdata valid after edge k.
- Read and write to the same register in the same cycle: io_rdata returns the pre-write value; written value visible to a read issued the next cycle.
- Write latency: leds/PB_EDGE/IRQ_EN update at the edge where io_we sampled high.
- Input latency: raw level changes before edge k → sync after edge k+1 → stable and PB_EDGE update at edge k+1+DEBOUNCE_CYCLES (with no bounce).
- Any bounce (sync returning to stable) restarts the count from 0.
- irq follows PB_EDGE/IRQ_EN by 1 cycle; W1C clear drops irq one cycle after the write edge.
- Reset asserted mid-debounce or mid-transfer: all state returns to reset values immediately; no partial write survives.

## Test plan

- Reset: hold reset=0 with pushbuttons=4'hF, random bus traffic → leds=0, io_rdata=0, irq=0; after release and 2+16 cycles, PB_LEVEL read =0xF, PB_EDGE=0xF.
- LED ops: write LED 0x3FF be=4'b0011 → leds=0x3FF; LED_CLR 0x0F0 → 0x30F; LED_SET 0x0F0 be=4'b0010 → unchanged 0x30F (byte 0 masked); LED read returns 0x30F, LED_SET read 0.
- Debounce: toggle pushbuttons[1] high for 10 cycles then low, then high for 20 → PB_LEVEL[1] rises exactly 18 cycles after the second rise; only one PB_EDGE set.
- Interrupt: IRQ_EN=0x2, stable rise on bit 1 → irq high 1 cycle after PB_EDGE[1]; rise on bit 0 alone → irq stays 0.
- W1C collision: write PB_EDGE 0x2 on the same edge bit 1 sets → PB_EDGE[1]=1, irq stays high; subsequent write 0x2 → cleared, irq low next cycle.
- Same-cycle read/write: write LED 0x155 with io_addr=0x04 → io_rdata shows old value, next cycle 0x155.

Source files
------------

// File: rtl/rv32_gpio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_gpio_ctrl_if
// Description : Word-addressed I/O bus between the RV32I data path and the
//               GPIO controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_gpio_ctrl_if;
  logic [31:2] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:0] io_rdata;

  modport master (
    output io_addr,
    output io_wdata,
    output io_we,
    output io_be,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_wdata,
    input  io_we,
    input  io_be,
    output io_rdata
  );
endinterface
`default_nettype wire

// File: rtl/rv32_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32_gpio_ctrl
// Description : Memory-mapped GPIO controller: debounced pushbuttons with
//               sticky W1C rising-edge flags, atomic LED set/clear, masked irq.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_gpio_ctrl #(
  parameter int NUM_PB          = 4,
  parameter int NUM_LED         = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  rv32_gpio_ctrl_if.slave         bus,
  input  wire logic [NUM_PB-1:0]  pushbuttons,
  output logic      [NUM_LED-1:0] leds,
  output logic                    irq
);

  localparam int                 c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [2:0] c_off_pb_level = 3'd0;
  localparam logic [2:0] c_off_led      = 3'd1;
  localparam logic [2:0] c_off_led_set  = 3'd2;
  localparam logic [2:0] c_off_led_clr  = 3'd3;
  localparam logic [2:0] c_off_pb_edge  = 3'd4;
  localparam logic [2:0] c_off_irq_en   = 3'd5;

  if (NUM_PB < 1 || NUM_PB > 32) begin : g_bad_num_pb
    $error("NUM_PB must be in 1..32");
  end
  if (NUM_LED < 1 || NUM_LED > 32) begin : g_bad_num_led
    $error("NUM_LED must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [NUM_PB-1:0]               r_sync1;
  logic [NUM_PB-1:0]               r_sync2;
  logic [NUM_PB-1:0][c_cnt_w-1:0]  r_cnt;
  logic [NUM_PB-1:0]               r_stable;
  logic [NUM_PB-1:0]               r_pb_edge;
  logic [NUM_PB-1:0]               r_irq_en;
  logic [NUM_LED-1:0]              r_leds;
  logic [31:0]                     r_rdata;
  logic                            r_irq;

  logic [NUM_PB-1:0][c_cnt_w-1:0]  w_cnt_nxt;
  logic [NUM_PB-1:0]               w_stable_nxt;
  logic [NUM_PB-1:0]               w_rise;
  logic [NUM_PB-1:0]               w_pb_edge_nxt;
  logic [NUM_PB-1:0]               w_irq_en_nxt;
  logic [NUM_LED-1:0]              w_leds_nxt;
  logic [31:0]                     w_rdata_nxt;
  logic [31:0]                     w_be_mask;
  logic [31:0]                     w_wr_bits;
  logic [NUM_LED-1:0]              w_led_mask;
  logic [NUM_LED-1:0]              w_led_data;
  logic [NUM_PB-1:0]               w_pb_mask;
  logic [NUM_PB-1:0]               w_pb_data;
  logic [2:0]                      w_off;
  logic                            w_unused;

  assign w_off      = bus.io_addr[4:2];
  assign w_be_mask  = {{8{bus.io_be[3]}}, {8{bus.io_be[2]}},
                       {8{bus.io_be[1]}}, {8{bus.io_be[0]}}};
  assign w_wr_bits  = bus.io_wdata & w_be_mask;
  assign w_led_mask = w_be_mask[NUM_LED-1:0];
  assign w_led_data = w_wr_bits[NUM_LED-1:0];
  assign w_pb_mask  = w_be_mask[NUM_PB-1:0];
  assign w_pb_data  = w_wr_bits[NUM_PB-1:0];
  assign w_unused   = ^{bus.io_addr[31:5], w_wr_bits};

  // Any return of sync to the accepted level restarts the stability count.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_rise       = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == c_cnt_max) begin
        w_stable_nxt[i] = r_sync2[i];
        w_cnt_nxt[i]    = '0;
        w_rise[i]       = r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + c_cnt_one;
      end
    end
  end

  always_comb begin
    w_leds_nxt = r_leds;
    if (bus.io_we) begin
      case (w_off)
        c_off_led:     w_leds_nxt = (r_leds & ~w_led_mask) | w_led_data;
        c_off_led_set: w_leds_nxt = r_leds | w_led_data;
        c_off_led_clr: w_leds_nxt = r_leds & ~w_led_data;
        default:       w_leds_nxt = r_leds;
      endcase
    end
  end

  // A rising edge landing on the same cycle as its W1C clear keeps the flag.
  always_comb begin
    w_pb_edge_nxt = r_pb_edge | w_rise;
    w_irq_en_nxt  = r_irq_en;
    if (bus.io_we && (w_off == c_off_pb_edge)) begin
      w_pb_edge_nxt = (r_pb_edge & ~w_pb_data) | w_rise;
    end
    if (bus.io_we && (w_off == c_off_irq_en)) begin
      w_irq_en_nxt = (r_irq_en & ~w_pb_mask) | w_pb_data;
    end
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (w_off)
      c_off_pb_level: w_rdata_nxt[NUM_PB-1:0]  = r_stable;
      c_off_led:      w_rdata_nxt[NUM_LED-1:0] = r_leds;
      c_off_pb_edge:  w_rdata_nxt[NUM_PB-1:0]  = r_pb_edge;
      c_off_irq_en:   w_rdata_nxt[NUM_PB-1:0]  = r_irq_en;
      default:        w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_pb_edge <= '0;
      r_irq_en  <= '0;
      r_leds    <= '0;
      r_rdata   <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_sync1   <= pushbuttons;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      r_pb_edge <= w_pb_edge_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_leds    <= w_leds_nxt;
      r_rdata   <= w_rdata_nxt;
      r_irq     <= |(r_pb_edge & r_irq_en);
    end
  end

  assign leds         = r_leds;
  assign irq          = r_irq;
  assign bus.io_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_gpio_ctrl
// Description : Self-checking bench for rv32_gpio_ctrl with a read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_gpio_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pushbuttons;
  logic [9:0] leds;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  string       q_tag[$];
  logic [31:0] q_exp[$];

  rv32_gpio_ctrl_if bus ();

  rv32_gpio_ctrl #(
    .NUM_PB          (4),
    .NUM_LED         (10),
    .DEBOUNCE_CYCLES (16)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .pushbuttons (pushbuttons),
    .leds        (leds),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    string       t;
    logic [31:0] e;
    if (q_exp.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got 0x%08h expected no output", got);
    end else begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    bus.io_addr  = {27'd0, off};
    bus.io_wdata = data;
    bus.io_be    = be;
    bus.io_we    = 1'b1;
    @(negedge clk);
    bus.io_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.io_addr = {27'd0, off};
    bus.io_we   = 1'b0;
    sb_push(tag, exp);
    @(negedge clk);
    sb_pop_check(bus.io_rdata);
  endtask

  initial begin
    reset        = 1'b0;
    pushbuttons  = 4'hF;
    bus.io_addr  = '0;
    bus.io_wdata = '0;
    bus.io_we    = 1'b0;
    bus.io_be    = 4'h0;

    // Random traffic while held in reset
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.io_addr  = 30'($urandom);
      bus.io_wdata = $urandom;
      bus.io_we    = 1'($urandom_range(1));
      bus.io_be    = 4'($urandom);
    end
    @(negedge clk);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_rdata", bus.io_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    bus.io_we = 1'b0;
    reset     = 1'b1;

    repeat (20) @(negedge clk);
    bus_read(3'd0, 32'hF, "pb_level_after_rst");
    bus_read(3'd4, 32'hF, "pb_edge_after_rst");
    check("irq_disabled", 32'(irq), 32'h0);
    bus_write(3'd4, 32'hF, 4'b0001);
    bus_read(3'd4, 32'h0, "pb_edge_w1c");
    pushbuttons = 4'h0;
    repeat (20) @(negedge clk);
    bus_read(3'd0, 32'h0, "pb_level_fall");
    bus_read(3'd4, 32'h0, "pb_edge_no_fall_flag");
    bus_write(3'd0, 32'hF, 4'hF);
    bus_read(3'd0, 32'h0, "pb_level_ro");

    // LED register and atomic set/clear
    bus_write(3'd1, 32'h3FF, 4'b0011);
    check("led_write", 32'(leds), 32'h3FF);
    bus_write(3'd3, 32'h0F0, 4'b1111);
    check("led_clr", 32'(leds), 32'h30F);
    bus_write(3'd2, 32'h0F0, 4'b0010);
    check("led_set_masked", 32'(leds), 32'h30F);
    bus_read(3'd1, 32'h30F, "led_read");
    bus_read(3'd2, 32'h0, "led_set_read");
    bus_read(3'd3, 32'h0, "led_clr_read");
    bus_read(3'd6, 32'h0, "unmapped_read");
    bus_write(3'd1, 32'h0, 4'b0010);
    check("led_byte1_only", 32'(leds), 32'h00F);
    bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd1, 32'h3FF, "led_upper_dropped");
    bus_write(3'd1, 32'h00F, 4'hF);

    // Same-cycle read and write of LED
    @(negedge clk);
    bus.io_addr  = 30'd1;
    bus.io_wdata = 32'h155;
    bus.io_be    = 4'hF;
    bus.io_we    = 1'b1;
    sb_push("rw_same_old", 32'h00F);
    @(negedge clk);
    bus.io_we = 1'b0;
    sb_pop_check(bus.io_rdata);
    sb_push("rw_same_new", 32'h155);
    @(negedge clk);
    sb_pop_check(bus.io_rdata);

    bus_write(3'd5, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd5, 32'hF, "irq_en_upper_dropped");
    bus_write(3'd5, 32'h2, 4'hF);
    bus_read(3'd5, 32'h2, "irq_en_read");

    // Debounce: short pulse rejected, long pulse accepted after 18 edges
    @(negedge clk);
    bus.io_addr    = 30'd0;
    pushbuttons[1] = 1'b1;
    repeat (10) @(negedge clk);
    pushbuttons[1] = 1'b0;
    repeat (5) @(negedge clk);
    pushbuttons[1] = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      sb_push($sformatf("deb_level_e%0d", m), (m >= 19) ? 32'h2 : 32'h0);
      @(negedge clk);
      sb_pop_check(bus.io_rdata);
      if (m >= 16) check($sformatf("deb_irq_e%0d", m), 32'(irq), (m >= 19) ? 32'h1 : 32'h0);
    end
    bus_read(3'd4, 32'h2, "deb_single_edge");

    bus_write(3'd4, 32'h2, 4'h1);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    check("w1c_irq_low", 32'(irq), 32'h0);

    // Masked source: bit 0 rise with enable clear
    pushbuttons[0] = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(3'd4, 32'h1, "pb0_edge");
    check("pb0_irq_masked", 32'(irq), 32'h0);

    // W1C clear coinciding with the rising edge of bit 1
    pushbuttons[1] = 1'b0;
    repeat (20) @(negedge clk);
    pushbuttons[1] = 1'b1;
    repeat (17) @(negedge clk);
    bus.io_addr  = 30'd4;
    bus.io_wdata = 32'h2;
    bus.io_be    = 4'h1;
    bus.io_we    = 1'b1;
    @(negedge clk);
    bus.io_we = 1'b0;
    @(negedge clk);
    check("collide_irq", 32'(irq), 32'h1);
    bus_read(3'd4, 32'h3, "collide_set_wins");
    bus_write(3'd4, 32'h2, 4'h1);
    check("clr2_irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    check("clr2_irq_low", 32'(irq), 32'h0);
    bus_read(3'd4, 32'h1, "clr2_edge");

    // Asynchronous reset in the middle of a write
    @(negedge clk);
    bus.io_addr  = 30'd1;
    bus.io_wdata = 32'h3FF;
    bus.io_be    = 4'hF;
    bus.io_we    = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds), 32'h0);
    check("async_rst_rdata", bus.io_rdata, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    bus.io_we = 1'b0;
    reset     = 1'b1;
    check("post_rst_leds", 32'(leds), 32'h0);
    bus_read(3'd4, 32'h0, "post_rst_edge");
    bus_read(3'd5, 32'h0, "post_rst_irq_en");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
